sky_renderer: RTL and testbench

Pipelined, parametrised sky background generator for the VGA pixel path. Given the current pixel coordinate, it produces the sky band colour and an `is_sky` flag two cycles later. A frame-driven day/dusk/night/dawn state machine crossfades between a day palette and a night palette. The block feeds the pixel mux ahead of sprite overlay (goose, obstacles, ground).

---
 rtl/sky_renderer.sv | 189 ++++++++++++++++++
 tb/tb_sky_renderer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sky_renderer.sv
// Two-stage sky background generator with a frame-driven day/dusk/night/dawn crossfade.
// Optional night stars are enabled by defining SKY_STARS_EN.
module sky_renderer #(
    parameter int COORD_W      = 10,
    parameter int BAND0_END    = 20,
    parameter int BAND1_END    = 60,
    parameter int BAND2_END    = 135,
    parameter int BAND3_END    = 235,
    parameter int SKY_END      = 384,
    parameter int PHASE_FRAMES = 600,
    parameter int STEP_FRAMES  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               cycle_en,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [11:0]        rgb,
    output logic               is_sky,
    output logic               out_valid,
    output logic [1:0]         phase,
    output logic [4:0]         alpha
);

`ifdef SKY_STARS_EN
    localparam bit STARS = 1'b1;
`else
    localparam bit STARS = 1'b0;
`endif

    localparam logic [1:0] DAY   = 2'd0;
    localparam logic [1:0] DUSK  = 2'd1;
    localparam logic [1:0] NIGHT = 2'd2;
    localparam logic [1:0] DAWN  = 2'd3;

    localparam int CNT_MAX = (PHASE_FRAMES > STEP_FRAMES) ? PHASE_FRAMES : STEP_FRAMES;
    localparam int FCNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    logic [FCNT_W-1:0] fcnt;
    logic              advance;
    logic              phase_done;
    logic              step_done;

    assign advance    = frame_tick & cycle_en;
    assign phase_done = (fcnt == FCNT_W'(PHASE_FRAMES - 1));
    assign step_done  = (fcnt == FCNT_W'(STEP_FRAMES - 1));

    // Phase FSM: frozen entirely while cycle_en is low; ticks are dropped, not queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= DAY;
            alpha <= 5'd0;
            fcnt  <= '0;
        end else if (advance) begin
            case (phase)
                DAY: begin
                    if (phase_done) begin
                        phase <= DUSK;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                DUSK: begin
                    if (step_done) begin
                        fcnt  <= '0;
                        alpha <= alpha + 5'd1;
                        if (alpha == 5'd15) phase <= NIGHT;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                NIGHT: begin
                    if (phase_done) begin
                        phase <= DAWN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    if (step_done) begin
                        fcnt  <= '0;
                        alpha <= alpha - 5'd1;
                        if (alpha == 5'd1) phase <= DAY;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic [2:0] band;
    logic       in_sky;

    always_comb begin
        band   = 3'd4;
        in_sky = 1'b1;
        if (y <= COORD_W'(BAND0_END))      band = 3'd0;
        else if (y <= COORD_W'(BAND1_END)) band = 3'd1;
        else if (y <= COORD_W'(BAND2_END)) band = 3'd2;
        else if (y <= COORD_W'(BAND3_END)) band = 3'd3;
        else if (y <= COORD_W'(SKY_END))   band = 3'd4;
        else                               in_sky = 1'b0;
    end

    logic               s1_valid;
    logic               s1_sky;
    logic [2:0]         s1_band;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sky   <= 1'b0;
            s1_band  <= 3'd0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_sky   <= pix_valid & in_sky;
            s1_band  <= band;
            s1_x     <= x;
            s1_y     <= y;
        end
    end

    function automatic logic [11:0] day_color(input logic [2:0] b);
        case (b)
            3'd0:    return 12'h138;
            3'd1:    return 12'h04d;
            3'd2:    return 12'h0af;
            3'd3:    return 12'h3df;
            default: return 12'haff;
        endcase
    endfunction

    function automatic logic [11:0] night_color(input logic [2:0] b);
        case (b)
            3'd0:    return 12'h001;
            3'd1:    return 12'h002;
            3'd2:    return 12'h013;
            3'd3:    return 12'h024;
            default: return 12'h035;
        endcase
    endfunction

    // Worst-case sum is 15*16 = 240, so 9 bits never overflow.
    function automatic logic [3:0] mix(input logic [3:0] d, input logic [3:0] n,
                                       input logic [4:0] a);
        logic [8:0] sum;
        sum = 9'(d) * 9'(5'd16 - a) + 9'(n) * 9'(a);
        return 4'(sum >> 4);
    endfunction

    logic [11:0]        day_c;
    logic [11:0]        night_c;
    logic [11:0]        blended;
    logic [COORD_W-1:0] star_sum;
    logic               star;

    assign day_c    = day_color(s1_band);
    assign night_c  = night_color(s1_band);
    assign blended  = {mix(day_c[11:8], night_c[11:8], alpha),
                       mix(day_c[7:4],  night_c[7:4],  alpha),
                       mix(day_c[3:0],  night_c[3:0],  alpha)};
    assign star_sum = s1_x + s1_y + (s1_y << 1);
    assign star     = STARS && (phase == NIGHT) && (s1_band <= 3'd2)
                      && ((star_sum & COORD_W'(63)) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= 12'h000;
            is_sky    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            is_sky    <= s1_sky;
            if (!s1_sky)   rgb <= 12'h000;
            else if (star) rgb <= 12'hfff;
            else           rgb <= blended;
        end
    end

endmodule

// File: tb/tb_sky_renderer.sv
// Directed/random bench for sky_renderer against an arithmetic model of the
// day/night schedule and band palette blend.
module tb_sky_renderer;

    localparam int P = 2;
    localparam int S = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        cycle_en;
    logic        pix_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        is_sky;
    logic        out_valid;
    logic [1:0]  phase;
    logic [4:0]  alpha;

    int checks = 0;
    int failures = 0;
    int ticks_seen = 0;
    logic [13:0] exp_q[$];

    int day_pal[5]   = '{'h138, 'h04d, 'h0af, 'h3df, 'haff};
    int night_pal[5] = '{'h001, 'h002, 'h013, 'h024, 'h035};
    int band_end[5]  = '{20, 60, 135, 235, 384};

    sky_renderer #(
        .PHASE_FRAMES(P),
        .STEP_FRAMES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .cycle_en  (cycle_en),
        .pix_valid (pix_valid),
        .x         (x),
        .y         (y),
        .rgb       (rgb),
        .is_sky    (is_sky),
        .out_valid (out_valid),
        .phase     (phase),
        .alpha     (alpha)
    );

    always #5 clk = ~clk;

    // Schedule position after n accepted ticks, one full cycle = 2P + 32S ticks.
    function automatic int model_phase();
        int t;
        t = ticks_seen % (2 * P + 32 * S);
        if (t < P) return 0;
        if (t < P + 16 * S) return 1;
        if (t < 2 * P + 16 * S) return 2;
        return 3;
    endfunction

    function automatic int model_alpha();
        int t;
        t = ticks_seen % (2 * P + 32 * S);
        if (t < P) return 0;
        if (t < P + 16 * S) return (t - P) / S;
        if (t < 2 * P + 16 * S) return 16;
        return 16 - (t - 2 * P - 16 * S) / S;
    endfunction

    function automatic logic [13:0] model_pixel(input int v, input int px, input int py);
        int b, a, r, d, n, sh;
        if (v == 0) return 14'h0000;
        if (py > 384) return 14'h2000;
        b = 0;
        while (py > band_end[b]) b++;
        a = model_alpha();
        r = 0;
        for (int c = 0; c < 3; c++) begin
            sh = 8 - 4 * c;
            d = (day_pal[b] >> sh) & 15;
            n = (night_pal[b] >> sh) & 15;
            r = r | (((d * (16 - a) + n * a) / 16) << sh);
        end
`ifdef SKY_STARS_EN
        if (model_phase() == 2 && b <= 2 && ((px + 3 * py) % 64) == 0) r = 'hfff;
`endif
        return 14'h3000 | 14'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one cycle, then checks the output due from two cycles back.
    task automatic step(input logic v, input int px, input int py, input logic tk,
                        input logic [13:0] exp);
        pix_valid  = v;
        x          = 10'(px);
        y          = 10'(py);
        frame_tick = tk;
        exp_q.push_back(exp);
        @(posedge clk);
        if (tk && cycle_en) ticks_seen++;
        @(negedge clk);
        if (exp_q.size() == 2) check("pixel", {out_valid, is_sky, rgb}, exp_q.pop_front());
        check("phase", 32'(phase), 32'(model_phase()));
        check("alpha", 32'(alpha), 32'(model_alpha()));
    endtask

    task automatic pix(input int px, input int py);
        step(1'b1, px, py, 1'b0, model_pixel(1, px, py));
    endtask

    task automatic pix_const(input int px, input int py, input logic [13:0] exp);
        step(1'b1, px, py, 1'b0, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 14'h0000);
    endtask

    task automatic rand_pixels(input int n);
        int v, px, py;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
            step(v[0], px, py, 1'b0, model_pixel(v, px, py));
        end
    endtask

    task automatic star_pixels(input int n);
        int px, py;
        for (int i = 0; i < n; i++) begin
            py = $urandom_range(0, 140);
            px = (1280 - 3 * py) % 640;
            pix(px, py);
        end
    endtask

    int   band_y[11];
    logic [11:0] band_rgb[11];

    initial begin
        band_y   = '{0, 20, 21, 60, 61, 135, 136, 235, 236, 384, 385};
        band_rgb = '{12'h138, 12'h138, 12'h04d, 12'h04d, 12'h0af, 12'h0af,
                     12'h3df, 12'h3df, 12'haff, 12'haff, 12'h000};

        reset = 1'b1;
        frame_tick = 1'b0;
        cycle_en = 1'b1;
        pix_valid = 1'b0;
        x = '0;
        y = '0;
        repeat (2) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_is_sky", 32'(is_sky), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_phase", 32'(phase), 32'h0);
        check("reset_alpha", 32'(alpha), 32'h0);
        reset = 1'b0;
        exp_q.push_back(14'h0000);

        for (int i = 0; i < 11; i++)
            pix_const(i * 37, band_y[i], {1'b1, (i < 10) ? 1'b1 : 1'b0, band_rgb[i]});
        rand_pixels(30);

        tick(P);
        check("dusk_entry", 32'(phase), 32'd1);
        tick(5);
        check("alpha_5", 32'(alpha), 32'd5);
        cycle_en = 1'b0;
        tick(10);
        check("freeze_alpha", 32'(alpha), 32'd5);
        check("freeze_phase", 32'(phase), 32'd1);
        cycle_en = 1'b1;
        tick(1);
        check("unfreeze_alpha", 32'(alpha), 32'd6);
        tick(2);
        pix_const(5, 0, 14'h3014);
        rand_pixels(20);

        tick(8);
        check("night_phase", 32'(phase), 32'd2);
        check("night_alpha", 32'(alpha), 32'd16);
        pix_const(100, 300, 14'h3035);
`ifdef SKY_STARS_EN
        pix_const(64, 0, 14'h3fff);
`else
        pix_const(64, 0, 14'h3001);
`endif
        pix_const(65, 0, 14'h3001);
        star_pixels(8);
        rand_pixels(20);

        tick(P);
        check("dawn_phase", 32'(phase), 32'd3);
        tick(7);
        rand_pixels(15);
        tick(16 * S - 7);
        check("day_return_phase", 32'(phase), 32'd0);
        check("day_return_alpha", 32'(alpha), 32'd0);
        pix_const(64, 0, 14'h3138);
        star_pixels(4);

        tick(P + 9 * S);
        check("pre_reset_alpha", 32'(alpha), 32'd9);
        pix(3, 10);
        pix(4, 10);
        pix(5, 400);
        #2 reset = 1'b1;
        #1;
        check("midreset_rgb", 32'(rgb), 32'h0);
        check("midreset_is_sky", 32'(is_sky), 32'h0);
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_phase", 32'(phase), 32'h0);
        check("midreset_alpha", 32'(alpha), 32'h0);
        ticks_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(14'h0000);
        pix(7, 0);
        pix(8, 50);
        rand_pixels(20);
        step(1'b0, 0, 0, 1'b0, 14'h0000);
        step(1'b0, 0, 0, 1'b0, 14'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
